// File: rtl/fnd_display_arbiter_pkg.sv
// Shared FND definitions (package fnd_pkg): state encoding, blank/message codes, source helpers.
// Used by the display arbiter, calculator and segment driver.
package fnd_pkg;

  localparam logic [0:0] FND_ST_IDLE = 1'b0;
  localparam logic [0:0] FND_ST_HOLD = 1'b1;

  localparam logic [31:0] FND_BLANK       = 32'h0000_0000;
  localparam logic [1:0]  FND_ACTIVE_NONE = 2'd3;

  localparam logic [31:0] FND_MSG_ERROR = 32'h00EE_0000;
  localparam logic [31:0] FND_MSG_PLUS  = 32'h0010_0000;
  localparam logic [31:0] FND_MSG_MINUS = 32'h0020_0000;
  localparam logic [31:0] FND_MSG_MUL   = 32'h0030_0000;
  localparam logic [31:0] FND_MSG_DIV   = 32'h0040_0000;
  localparam logic [31:0] FND_MSG_MOD   = 32'h0050_0000;
  localparam logic [31:0] FND_MSG_HAPPY = 32'h00A0_0000;

  typedef logic [1:0] fnd_src_t;

  // Lowest index wins; returns FND_ACTIVE_NONE when nothing is requesting.
  function automatic fnd_src_t fnd_prio(input logic [2:0] req);
    if (req[0]) return 2'd0;
    if (req[1]) return 2'd1;
    if (req[2]) return 2'd2;
    return FND_ACTIVE_NONE;
  endfunction

  function automatic logic [2:0] fnd_onehot(input fnd_src_t src);
    return 3'b001 << src;
  endfunction

endpackage

// File: rtl/fnd_display_arbiter_if.sv
// Request/display bus between the message sources and the FND display arbiter.
interface fnd_display_arbiter_if;
  logic [2:0]  req;
  logic [95:0] req_data;
  logic [31:0] default_data;
  logic [2:0]  grant;
  logic [31:0] fnd_serial;
  logic        busy;
  logic [1:0]  active_src;

  modport master (
    output req, req_data, default_data,
    input  grant, fnd_serial, busy, active_src
  );

  modport slave (
    input  req, req_data, default_data,
    output grant, fnd_serial, busy, active_src
  );
endinterface

// File: rtl/fnd_display_arbiter_hold_timer.sv
// fnd_hold_timer: loadable down-counter that stops at zero; expired is high while count==0.
module fnd_hold_timer #(
  parameter  int unsigned CYCLES = 8,
  localparam int unsigned W      = $clog2(CYCLES + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - W'(1);
  end

  assign expired = (count == '0);

endmodule

// File: rtl/fnd_display_arbiter.sv
// Priority arbiter that holds one source's message on the FND for HOLD_CYCLES cycles.
// Optional blinking of the held message is enabled with macro FND_BLINK_EN.
module fnd_display_arbiter
  import fnd_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic                 clk,
  input  logic                 rst,
  fnd_display_arbiter_if.slave bus
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  logic [0:0]  state;
  fnd_src_t    active_q;
  fnd_src_t    win;
  logic [31:0] win_data;
  logic [31:0] serial_q;
  logic [2:0]  grant_q;
  logic [2:0]  higher_mask;
  logic        any_req;
  logic        preempt;
  logic        take;
  logic        hold_expired;

  assign any_req = |bus.req;
  assign win     = fnd_prio(bus.req);

  always_comb begin
    win_data = FND_BLANK;
    case (win)
      2'd0:    win_data = bus.req_data[31:0];
      2'd1:    win_data = bus.req_data[63:32];
      2'd2:    win_data = bus.req_data[95:64];
      default: win_data = FND_BLANK;
    endcase
  end

  // Only sources with a lower index than the held one may cut in.
  always_comb begin
    higher_mask = '0;
    for (int unsigned i = 0; i < 3; i++)
      if (i < 32'(active_q)) higher_mask[i] = 1'b1;
  end

  assign preempt = (state == FND_ST_HOLD) && |(bus.req & higher_mask);
  assign take    = (state == FND_ST_IDLE) ? any_req
                                          : (preempt || (hold_expired && any_req));

  fnd_hold_timer #(.CYCLES(HOLD_CYCLES)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (take),
    .load_val (HW'(HOLD_CYCLES - 1)),
    .expired  (hold_expired)
  );

`ifdef FND_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);

  logic        blink_expired;
  logic        blink_load;
  logic        blink_show;
  logic [31:0] held_code;

  assign blink_load = take || ((state == FND_ST_HOLD) && blink_expired);

  fnd_hold_timer #(.CYCLES(BLINK_CYCLES)) u_blink (
    .clk      (clk),
    .rst      (rst),
    .load     (blink_load),
    .load_val (BW'(BLINK_CYCLES - 1)),
    .expired  (blink_expired)
  );
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = ^BLINK_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FND_ST_IDLE;
      active_q <= FND_ACTIVE_NONE;
      serial_q <= FND_BLANK;
      grant_q  <= '0;
`ifdef FND_BLINK_EN
      blink_show <= 1'b1;
      held_code  <= FND_BLANK;
`endif
    end else begin
      grant_q <= '0;
      if (take) begin
        state    <= FND_ST_HOLD;
        active_q <= win;
        serial_q <= win_data;
        grant_q  <= fnd_onehot(win);
`ifdef FND_BLINK_EN
        blink_show <= 1'b1;
        held_code  <= win_data;
`endif
      end else if (state == FND_ST_IDLE) begin
        serial_q <= bus.default_data;
      end else if (hold_expired) begin
        state    <= FND_ST_IDLE;
        active_q <= FND_ACTIVE_NONE;
        serial_q <= bus.default_data;
      end else begin
`ifdef FND_BLINK_EN
        // Phase flips each time the blink timer runs out; the new phase is shown on this edge.
        if (blink_expired) begin
          blink_show <= ~blink_show;
          serial_q   <= blink_show ? FND_BLANK : held_code;
        end
`endif
      end
    end
  end

  assign bus.grant      = grant_q;
  assign bus.fnd_serial = serial_q;
  assign bus.busy       = (state == FND_ST_HOLD);
  assign bus.active_src = active_q;

endmodule

// File: tb/tb_fnd_display_arbiter.sv
// Directed self-checking bench for fnd_display_arbiter (HOLD_CYCLES=8 and 1, BLINK_CYCLES=2).
module tb_fnd_display_arbiter;
  import fnd_pkg::*;

  localparam int TB_HOLD  = 8;
  localparam int TB_BLINK = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fnd_display_arbiter_if bus();
  fnd_display_arbiter_if bus1();

  fnd_display_arbiter #(.HOLD_CYCLES(TB_HOLD), .BLINK_CYCLES(TB_BLINK)) u_dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  fnd_display_arbiter #(.HOLD_CYCLES(1), .BLINK_CYCLES(TB_BLINK)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  typedef struct {
    logic [2:0]  req;
    logic [31:0] dd;
    logic [31:0] serial;
    logic [2:0]  grant;
    logic        busy;
    logic [1:0]  act;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  // Expected display k cycles after a grant (k=0 is the grant edge).
  function automatic logic [31:0] held(input logic [31:0] code, input int k);
`ifdef FND_BLINK_EN
    return (((k / TB_BLINK) % 2) == 0) ? code : 32'h0;
`else
    return code;
`endif
  endfunction

  function automatic vec_t mk(input logic [2:0] req, input logic [31:0] dd, input logic [31:0] s,
                              input logic [2:0] g, input logic b, input logic [1:0] a);
    vec_t v;
    v.req = req; v.dd = dd; v.serial = s; v.grant = g; v.busy = b; v.act = a;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int which, input logic [31:0] s,
                         input logic [2:0] g, input logic b, input logic [1:0] a);
    if (which == 0) begin
      chk({tag, ".serial"}, bus.fnd_serial, s);
      chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
      chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
      chk({tag, ".active"}, 32'(bus.active_src), 32'(a));
    end else begin
      chk({tag, ".serial"}, bus1.fnd_serial, s);
      chk({tag, ".grant"}, 32'(bus1.grant), 32'(g));
      chk({tag, ".busy"}, 32'(bus1.busy), 32'(b));
      chk({tag, ".active"}, 32'(bus1.active_src), 32'(a));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n hold cycles following a grant, starting at offset k0, with no grant expected.
  task automatic hold_run(input string tag, input logic [31:0] code, input int k0, input int n,
                          input logic [1:0] a);
    for (int k = k0; k < k0 + n; k++) begin
      tick();
      chk_out($sformatf("%s_h%0d", tag, k), 0, held(code, k), 3'b000, 1'b1, a);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0;  bus.default_data = '0;
    bus.req_data = {FND_MSG_PLUS, FND_MSG_MINUS, FND_MSG_ERROR};
    bus1.req = '0; bus1.default_data = 32'd42;
    bus1.req_data = {FND_MSG_PLUS, FND_MSG_MINUS, FND_MSG_ERROR};

    tick(); tick();
    chk_out("reset", 0, FND_BLANK, 3'b000, 1'b0, FND_ACTIVE_NONE);
    chk_out("reset1", 1, FND_BLANK, 3'b000, 1'b0, FND_ACTIVE_NONE);
    rst = 1'b0;

    // Idle passthrough, single grant from src2, 8-cycle hold, return to live data.
    tbl.push_back(mk(3'b000, 32'd1234, 32'd1234, 3'b000, 1'b0, 2'd3));
    tbl.push_back(mk(3'b000, 32'd5678, 32'd5678, 3'b000, 1'b0, 2'd3));
    tbl.push_back(mk(3'b100, 32'd5678, FND_MSG_PLUS, 3'b100, 1'b1, 2'd2));
    for (int k = 1; k < TB_HOLD; k++)
      tbl.push_back(mk(3'b000, 32'd5678, held(FND_MSG_PLUS, k), 3'b000, 1'b1, 2'd2));
    tbl.push_back(mk(3'b000, 32'd5678, 32'd5678, 3'b000, 1'b0, 2'd3));
    tbl.push_back(mk(3'b000, 32'd9, 32'd9, 3'b000, 1'b0, 2'd3));

    for (int i = 0; i < tbl.size(); i++) begin
      bus.req = tbl[i].req;
      bus.default_data = tbl[i].dd;
      tick();
      chk_out($sformatf("vec%0d", i), 0, tbl[i].serial, tbl[i].grant, tbl[i].busy, tbl[i].act);
    end

    // Preemption by src0, lower-priority src1 waits, then back-to-back on expiry.
    bus.default_data = 32'd5678;
    bus.req = 3'b100;
    tick(); chk_out("pre_g2", 0, FND_MSG_PLUS, 3'b100, 1'b1, 2'd2);
    bus.req = 3'b000;
    hold_run("pre_s2", FND_MSG_PLUS, 1, 2, 2'd2);
    bus.req = 3'b001;
    tick(); chk_out("pre_g0", 0, FND_MSG_ERROR, 3'b001, 1'b1, 2'd0);
    bus.req = 3'b010;
    hold_run("pre_s0", FND_MSG_ERROR, 1, TB_HOLD - 1, 2'd0);
    tick(); chk_out("pre_g1", 0, FND_MSG_MINUS, 3'b010, 1'b1, 2'd1);
    bus.req = 3'b000;
    hold_run("pre_s1", FND_MSG_MINUS, 1, TB_HOLD - 1, 2'd1);
    tick(); chk_out("pre_idle", 0, 32'd5678, 3'b000, 1'b0, 2'd3);

    // Simultaneous requests in idle, src2 kept high for a back-to-back grant.
    bus.req = 3'b110;
    tick(); chk_out("sim_g1", 0, FND_MSG_MINUS, 3'b010, 1'b1, 2'd1);
    bus.req = 3'b100;
    hold_run("sim_s1", FND_MSG_MINUS, 1, TB_HOLD - 1, 2'd1);
    tick(); chk_out("sim_g2", 0, FND_MSG_PLUS, 3'b100, 1'b1, 2'd2);
    bus.req = 3'b000;
    hold_run("sim_s2", FND_MSG_PLUS, 1, TB_HOLD - 1, 2'd2);
    tick(); chk_out("sim_idle", 0, 32'd5678, 3'b000, 1'b0, 2'd3);

    // Reset in the middle of a hold aborts it without any grant.
    bus.req = 3'b100;
    tick(); chk_out("rst_g2", 0, FND_MSG_PLUS, 3'b100, 1'b1, 2'd2);
    bus.req = 3'b000;
    hold_run("rst_s2", FND_MSG_PLUS, 1, 3, 2'd2);
    rst = 1'b1;
    bus.req = 3'b100;
    tick(); chk_out("rst_abort", 0, FND_BLANK, 3'b000, 1'b0, 2'd3);
    tick(); chk_out("rst_held", 0, FND_BLANK, 3'b000, 1'b0, 2'd3);
    rst = 1'b0;
    bus.req = 3'b000;
    bus.default_data = 32'd77;
    tick(); chk_out("rst_idle", 0, 32'd77, 3'b000, 1'b0, 2'd3);

    // HOLD_CYCLES=1: grants on consecutive cycles, then straight back to idle.
    bus1.req = 3'b011;
    tick(); chk_out("h1_g0", 1, FND_MSG_ERROR, 3'b001, 1'b1, 2'd0);
    bus1.req = 3'b010;
    tick(); chk_out("h1_g1", 1, FND_MSG_MINUS, 3'b010, 1'b1, 2'd1);
    bus1.req = 3'b000;
    tick(); chk_out("h1_idle", 1, 32'd42, 3'b000, 1'b0, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fnd_display_arbiter.md
FND_DISPLAY_ARBITER -- requirements
Module: fnd_display_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 50_000_000, SHALL set the message display time in clk cycles; legal range is 1 or greater.
REQ-002 Parameter BLINK_CYCLES, default 12_500_000, SHALL set the blink half-period in clk cycles; it is used only under FND_BLINK_EN.
REQ-003 clk  in  1  SHALL be the single clock; every flop updates on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 req  in  3  SHALL carry level requests from three sources; req[0] has the highest priority.
REQ-006 req_data  in  96  SHALL carry one 32-bit display code per source; source k uses bits [32k+31:32k].
REQ-007 default_data  in  32  SHALL be the live display code, shown while no message is held.
REQ-008 grant  out  3  SHALL be a one-hot, one-cycle pulse that acknowledges the latched source.
REQ-009 fnd_serial  out  32  SHALL be the registered code driven to the segment driver.
REQ-010 busy  out  1  SHALL be high while a message is held.
REQ-011 active_src  out  2  SHALL give the index of the held source, or 3 when idle.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and HOLD.
REQ-013 In IDLE with req==0, fnd_serial SHALL equal default_data with one cycle of latency.
REQ-014 In IDLE, the edge after any req bit is sampled high SHALL do all of the following:
  - select the highest-priority requester k;
  - latch req_data[k] into fnd_serial;
  - pulse grant[k];
  - enter HOLD;
  - load the hold counter with HOLD_CYCLES-1.
REQ-015 In HOLD, the counter SHALL decrement once per cycle, so a latched message stays on fnd_serial for exactly HOLD_CYCLES cycles.
REQ-016 When the counter is 0 in HOLD with no request pending, the next state SHALL be IDLE, and default_data SHALL appear on the following edge.
REQ-017 When the counter is 0 in HOLD and any req is high, the arbiter SHALL grant directly back-to-back, with no IDLE cycle.
REQ-018 In HOLD, a req bit strictly higher in priority than active_src SHALL preempt immediately: latch, grant and reload the counter on the next edge.
REQ-019 In HOLD, equal- or lower-priority requests SHALL wait and SHALL receive no grant until expiry.
REQ-020 A requester SHALL keep req high until it sees its grant; a request dropped before grant SHALL be discarded silently.
REQ-021 A requester whose grant and continued req coincide SHALL be re-arbitrated as a new request only after its hold expires.
REQ-022 At most one grant bit SHALL be high in any cycle.
REQ-023 With HOLD_CYCLES=1, each message SHALL be shown for one cycle, and back-to-back grants SHALL be possible on consecutive cycles.

Reset
REQ-024 While rst is high, the block SHALL drive state=IDLE, counter=0, fnd_serial=0, grant=0, busy=0 and active_src=3.
REQ-025 A rst assertion during HOLD SHALL abort the message on that edge with no grant.
REQ-026 After rst deasserts, the first cycle SHALL behave as IDLE.

Configuration
REQ-027 With macro FND_BLINK_EN defined, fnd_serial SHALL alternate between the held code and FND_BLANK (32'h0000_0000) every BLINK_CYCLES cycles during HOLD, starting with the held code at grant.
REQ-028 On every grant or preemption, the blink phase counter SHALL reset.
REQ-029 Without FND_BLINK_EN, the held code SHALL be steady and no blink counter SHALL be synthesised.

Structure
REQ-030 Shared package fnd_pkg SHALL hold the following, shared with the calculator and segment driver:
  - state encoding FND_ST_IDLE/FND_ST_HOLD;
  - FND_BLANK;
  - FND_ACTIVE_NONE=3;
  - message codes FND_MSG_ERROR (32'h00EE_0000), FND_MSG_PLUS (32'h0010_0000), FND_MSG_MINUS (32'h0020_0000), FND_MSG_MUL (32'h0030_0000), FND_MSG_DIV (32'h0040_0000), FND_MSG_MOD (32'h0050_0000), FND_MSG_HAPPY (32'h00A0_0000).
REQ-031 One sub-module, fnd_hold_timer, SHALL implement a loadable down-counter with width $clog2(HOLD_CYCLES+1), inputs load and load_val, and output expired (high when count==0); the blink counter SHALL reuse it.

Verification (HOLD_CYCLES=8, BLINK_CYCLES=2 for sim)
REQ-032 Idle passthrough: rst then default_data=32'd1234 with req=0 -> fnd_serial=1234 one cycle later; busy=0; active_src=3.
REQ-033 Single grant: req[2]=1 with data 32'h0010_0000 -> next cycle grant=3'b100, fnd_serial=32'h0010_0000 for exactly 8 cycles, then default_data.
REQ-034 Preemption: hold src2, then at cycle 3 raise req[0]=32'h00EE_0000 -> next edge grant=3'b001, fnd_serial=32'h00EE_0000, counter reloaded, held 8 more cycles.
REQ-035 Simultaneous and back-to-back: req=3'b110 in IDLE -> grant=3'b010 first; req[2] kept high -> grant=3'b100 the cycle after expiry, with no IDLE cycle.
REQ-036 Reset mid-hold: rst at hold cycle 4 -> fnd_serial=0, busy=0 and grant=0 on that edge.
REQ-037 Blink build (FND_BLINK_EN): grant of 32'h00A0_0000 -> fnd_serial pattern A,A,0,0,A,A,0,0 over the 8 hold cycles.
